// File: rtl/uart_pkg.sv
// Shared UART hub definitions: control characters, line-assembler states, width helper.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package uart_pkg;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_DEL = 8'h7F;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SEND    = 2'd1,
    ACK_LO  = 2'd2,
    ACK_HI  = 2'd3
  } la_state_e;

endpackage

// File: rtl/uart_line_assembler_if.sv
// Receiver-side, transmitter-side and status signals of the line assembler.
interface uart_line_assembler_if #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
);
  localparam int LW = `CLOG2(DEPTH) + 1;

  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] tx_char;
  logic             tx_new_data;
  logic             tx_rdy;
  logic [LW-1:0]    line_len;
  logic             busy;
  logic             overflow;
  logic             dropped;

  // master: the line assembler itself
  modport master (
    input  rx_data, rx_valid, tx_rdy,
    output tx_char, tx_new_data, line_len, busy, overflow, dropped
  );

  // slave: receiver/transmitter/status environment around it
  modport slave (
    output rx_data, rx_valid, tx_rdy,
    input  tx_char, tx_new_data, line_len, busy, overflow, dropped
  );
endinterface

// File: rtl/uart_line_assembler_line_ram.sv
// Line buffer: synchronous write, asynchronous read, no reset so it maps onto FPGA RAM.
module line_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [`CLOG2(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic [`CLOG2(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]           rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_line_assembler.sv
// Line editor: collects received bytes with backspace editing, replays the line plus CR LF
// to the transmitter on CR using a full rdy low/high handshake per byte.
module uart_line_assembler
  import uart_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_line_assembler_if.master bus
);

  localparam int              AW      = `CLOG2(DEPTH);
  localparam int              LW      = AW + 1;
  localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]   ONE     = LW'(1);

  la_state_e        state_q, state_d;
  logic [LW-1:0]    line_len_q, line_len_d;
  logic [LW-1:0]    emit_len_q, emit_len_d;
  logic [LW-1:0]    emit_idx_q, emit_idx_d;
  logic [WIDTH-1:0] tx_char_q, tx_char_d;
  logic             tx_new_q, tx_new_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;

  logic             ram_we;
  logic [WIDTH-1:0] ram_rdata;

  line_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_line_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (line_len_q[AW-1:0]),
    .wdata_i (bus.rx_data),
    .raddr_i (emit_idx_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    line_len_d = line_len_q;
    emit_len_d = emit_len_q;
    emit_idx_d = emit_idx_q;
    tx_char_d  = tx_char_q;
    tx_new_d   = 1'b0;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    ram_we     = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == WIDTH'(CHAR_CR)) begin
            emit_len_d = line_len_q;
            emit_idx_d = '0;
            busy_d     = 1'b1;
            ovf_d      = 1'b0;
            state_d    = SEND;
          end else if (bus.rx_data == WIDTH'(CHAR_LF)) begin
            line_len_d = line_len_q;
          end else if (bus.rx_data == WIDTH'(CHAR_BS) || bus.rx_data == WIDTH'(CHAR_DEL)) begin
            if (line_len_q != '0) line_len_d = line_len_q - ONE;
          end else if (line_len_q < DEPTH_L) begin
            ram_we     = 1'b1;
            line_len_d = line_len_q + ONE;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.tx_rdy) begin
          tx_new_d = 1'b1;
          if (emit_idx_q < emit_len_q)       tx_char_d = ram_rdata;
          else if (emit_idx_q == emit_len_q) tx_char_d = WIDTH'(CHAR_CR);
          else                               tx_char_d = WIDTH'(CHAR_LF);
          state_d = ACK_LO;
        end
      end
      ACK_LO: begin
        if (!bus.tx_rdy) state_d = ACK_HI;
      end
      ACK_HI: begin
        if (bus.tx_rdy) begin
          if (emit_idx_q == emit_len_q + ONE) begin
            line_len_d = '0;
            busy_d     = 1'b0;
            state_d    = COLLECT;
          end else begin
            emit_idx_d = emit_idx_q + ONE;
            state_d    = SEND;
          end
        end
      end
      default: state_d = COLLECT;
    endcase

    // Anything arriving outside COLLECT is lost, including the final ACK_HI exit cycle.
    if (bus.rx_valid && state_q != COLLECT) drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      line_len_q <= '0;
      emit_len_q <= '0;
      emit_idx_q <= '0;
      tx_char_q  <= '0;
      tx_new_q   <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_len_q <= line_len_d;
      emit_len_q <= emit_len_d;
      emit_idx_q <= emit_idx_d;
      tx_char_q  <= tx_char_d;
      tx_new_q   <= tx_new_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.tx_char     = tx_char_q;
  assign bus.tx_new_data = tx_new_q;
  assign bus.line_len    = line_len_q;
  assign bus.busy        = busy_q;
  assign bus.overflow    = ovf_q;
  assign bus.dropped     = drop_q;

endmodule

// File: tb/tb_uart_line_assembler.sv
// Directed bench for uart_line_assembler: a DEPTH=64 and a DEPTH=4 instance, each with a transmitter model.
module tb_uart_line_assembler;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_line_assembler_if #(.DEPTH(64), .WIDTH(8)) bus64 ();
  uart_line_assembler_if #(.DEPTH(4),  .WIDTH(8)) bus4 ();

  uart_line_assembler #(.DEPTH(64), .WIDTH(8)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
  uart_line_assembler #(.DEPTH(4),  .WIDTH(8)) u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] rxd [2];
  logic       rxv [2];
  logic       rdy [2];
  logic       stb [2];
  logic [7:0] chr [2];
  logic       bsy [2];
  logic       hold_high;
  int         cnt [2];

  assign bus64.rx_data  = rxd[0];
  assign bus64.rx_valid = rxv[0];
  assign bus64.tx_rdy   = rdy[0];
  assign bus4.rx_data   = rxd[1];
  assign bus4.rx_valid  = rxv[1];
  assign bus4.tx_rdy    = rdy[1];
  assign stb[0] = bus64.tx_new_data;
  assign stb[1] = bus4.tx_new_data;
  assign chr[0] = bus64.tx_char;
  assign chr[1] = bus4.tx_char;
  assign bsy[0] = bus64.busy;
  assign bsy[1] = bus4.busy;

  // Transmitter model: rdy drops the cycle after a strobe and stays low for 10 clocks.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (hold_high) begin
        rdy[i] <= 1'b1;
        cnt[i] <= 0;
      end else if (stb[i]) begin
        rdy[i] <= 1'b0;
        cnt[i] <= 10;
      end else if (cnt[i] != 0) begin
        cnt[i] <= cnt[i] - 1;
        if (cnt[i] == 1) rdy[i] <= 1'b1;
      end
    end
  end

  int cap0 [$];
  int cap1 [$];
  logic prev_stb [2];
  logic prev_bsy [2];

  always @(negedge clk) begin
    if (stb[0]) cap0.push_back(int'(chr[0]));
    if (stb[1]) cap1.push_back(int'(chr[1]));
    for (int i = 0; i < 2; i++) begin
      if (stb[i]) begin
        n_chk++;
        if (prev_stb[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL strobe_width[%0d]: tx_new_data high for 2+ cycles, required 1", i);
        end
      end
      if (prev_bsy[i] === 1'b1 && bsy[i] === 1'b0) begin
        n_chk++;
        if ((i == 0 ? int'(bus64.line_len) : int'(bus4.line_len)) != 0) begin
          n_fail++;
          $display("FAIL busy_fall_len[%0d]: line_len=%0d when busy fell, required 0", i,
                   (i == 0 ? int'(bus64.line_len) : int'(bus4.line_len)));
        end
      end
      prev_stb[i] = stb[i];
      prev_bsy[i] = bsy[i];
    end
  end

  task automatic send_byte(input int sel, input logic [7:0] b);
    rxd[sel] = b;
    rxv[sel] = 1'b1;
    @(negedge clk);
    rxv[sel] = 1'b0;
    rxd[sel] = 8'h00;
  endtask

  task automatic wait_idle(input int sel, input string name);
    int k = 0;
    while (bsy[sel] === 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (k >= 400) begin
      n_fail++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, k);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cap0.delete();
    cap1.delete();
  endtask

  task automatic test_reset();
    if (bus64.line_len !== 7'd0)   begin n_fail++; $display("FAIL rst_len: got %0d, required 0", bus64.line_len); end
    if (bus64.busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b, required 0", bus64.busy); end
    if (bus64.tx_new_data !== 1'b0) begin n_fail++; $display("FAIL rst_stb: got %b, required 0", bus64.tx_new_data); end
    if (bus64.tx_char !== 8'h00)   begin n_fail++; $display("FAIL rst_char: got %h, required 00", bus64.tx_char); end
    if (bus64.overflow !== 1'b0)   begin n_fail++; $display("FAIL rst_ovf: got %b, required 0", bus64.overflow); end
    if (bus64.dropped !== 1'b0)    begin n_fail++; $display("FAIL rst_drop: got %b, required 0", bus64.dropped); end
    if (bus4.line_len !== 3'd0)    begin n_fail++; $display("FAIL rst_len4: got %0d, required 0", bus4.line_len); end
    n_chk += 7;
  endtask

  task automatic test_abc();
    int exp [$] = '{'h61, 'h62, 'h63, 'h0D, 'h0A};
    int got;
    cap0.delete();
    send_byte(0, 8'h61); send_byte(0, 8'h62); send_byte(0, 8'h63);
    n_chk++;
    if (bus64.line_len !== 7'd3) begin n_fail++; $display("FAIL abc_len: got %0d, required 3", bus64.line_len); end
    send_byte(0, CHAR_CR);
    n_chk += 2;
    if (bus64.busy !== 1'b1) begin n_fail++; $display("FAIL abc_busy_t1: got %b, required 1", bus64.busy); end
    if (bus64.tx_new_data !== 1'b0) begin n_fail++; $display("FAIL abc_stb_t1: got %b, required 0", bus64.tx_new_data); end
    @(negedge clk);
    n_chk += 2;
    if (bus64.tx_new_data !== 1'b1) begin n_fail++; $display("FAIL abc_stb_t2: got %b, required 1", bus64.tx_new_data); end
    if (bus64.tx_char !== 8'h61) begin n_fail++; $display("FAIL abc_char_t2: got %h, required 61", bus64.tx_char); end
    wait_idle(0, "abc");
    n_chk++;
    if (cap0.size() != exp.size()) begin n_fail++; $display("FAIL abc_count: got %0d strobes, required %0d", cap0.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < cap0.size()) ? cap0[i] : -1;
      n_chk++;
      if (got != exp[i]) begin n_fail++; $display("FAIL abc_byte%0d: got %0h, required %0h", i, got, exp[i]); end
    end
    n_chk += 2;
    if (bus64.line_len !== 7'd0) begin n_fail++; $display("FAIL abc_len_end: got %0d, required 0", bus64.line_len); end
    if (bus64.busy !== 1'b0) begin n_fail++; $display("FAIL abc_busy_end: got %b, required 0", bus64.busy); end
  endtask

  task automatic test_backspace();
    int exp [$] = '{'h61, 'h63, 'h0D, 'h0A};
    int got;
    cap0.delete();
    send_byte(0, CHAR_BS);
    n_chk++;
    if (bus64.line_len !== 7'd0) begin n_fail++; $display("FAIL bs_empty: got %0d, required 0", bus64.line_len); end
    send_byte(0, CHAR_DEL);
    n_chk++;
    if (bus64.line_len !== 7'd0) begin n_fail++; $display("FAIL del_empty: got %0d, required 0", bus64.line_len); end
    send_byte(0, 8'h61); send_byte(0, 8'h62); send_byte(0, CHAR_BS); send_byte(0, 8'h63);
    n_chk++;
    if (bus64.line_len !== 7'd2) begin n_fail++; $display("FAIL bs_len: got %0d, required 2", bus64.line_len); end
    send_byte(0, CHAR_CR);
    wait_idle(0, "bs");
    n_chk++;
    if (cap0.size() != exp.size()) begin n_fail++; $display("FAIL bs_count: got %0d strobes, required %0d", cap0.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < cap0.size()) ? cap0[i] : -1;
      n_chk++;
      if (got != exp[i]) begin n_fail++; $display("FAIL bs_byte%0d: got %0h, required %0h", i, got, exp[i]); end
    end
  endtask

  task automatic test_overflow();
    int exp [$] = '{'h61, 'h62, 'h63, 'h64, 'h0D, 'h0A};
    int got;
    cap1.delete();
    for (int i = 0; i < 6; i++) send_byte(1, 8'(8'h61 + i));
    n_chk += 2;
    if (bus4.line_len !== 3'd4) begin n_fail++; $display("FAIL ovf_len: got %0d, required 4", bus4.line_len); end
    if (bus4.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", bus4.overflow); end
    send_byte(1, CHAR_CR);
    n_chk++;
    if (bus4.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b, required 0", bus4.overflow); end
    wait_idle(1, "ovf");
    n_chk++;
    if (cap1.size() != exp.size()) begin n_fail++; $display("FAIL ovf_count: got %0d strobes, required %0d", cap1.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < cap1.size()) ? cap1[i] : -1;
      n_chk++;
      if (got != exp[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %0h, required %0h", i, got, exp[i]); end
    end
    n_chk++;
    if (bus4.line_len !== 3'd0) begin n_fail++; $display("FAIL ovf_len_end: got %0d, required 0", bus4.line_len); end
  endtask

  task automatic test_empty_line();
    send_byte(0, 8'h7A);
    send_byte(0, CHAR_LF);
    n_chk++;
    if (bus64.line_len !== 7'd1) begin n_fail++; $display("FAIL lf_ignored: got %0d, required 1", bus64.line_len); end
    send_byte(0, CHAR_BS);
    cap0.delete();
    send_byte(0, CHAR_CR);
    wait_idle(0, "empty");
    n_chk += 3;
    if (cap0.size() != 2) begin n_fail++; $display("FAIL empty_count: got %0d strobes, required 2", cap0.size()); end
    if ((cap0.size() > 0 ? cap0[0] : -1) != 'h0D) begin n_fail++; $display("FAIL empty_cr: got %0h, required d", (cap0.size() > 0 ? cap0[0] : -1)); end
    if ((cap0.size() > 1 ? cap0[1] : -1) != 'h0A) begin n_fail++; $display("FAIL empty_lf: got %0h, required a", (cap0.size() > 1 ? cap0[1] : -1)); end
  endtask

  task automatic test_dropped();
    int k = 0;
    do_reset();
    send_byte(0, 8'h6B);
    send_byte(0, CHAR_CR);
    while (cap0.size() < 3 && k < 300) begin @(negedge clk); k++; end
    while (bus64.tx_rdy !== 1'b0 && k < 300) begin @(negedge clk); k++; end
    while (bus64.tx_rdy !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    n_chk += 3;
    if (k >= 300) begin n_fail++; $display("FAIL drop_exit_timeout: waited %0d cycles, required < 300", k); end
    if (bus64.busy !== 1'b1) begin n_fail++; $display("FAIL drop_exit_busy: got %b, required 1", bus64.busy); end
    if (bus64.dropped !== 1'b0) begin n_fail++; $display("FAIL drop_pre: got %b, required 0", bus64.dropped); end
    send_byte(0, 8'h71);
    n_chk += 3;
    if (bus64.dropped !== 1'b1) begin n_fail++; $display("FAIL drop_exit_flag: got %b, required 1", bus64.dropped); end
    if (bus64.busy !== 1'b0) begin n_fail++; $display("FAIL drop_exit_idle: got %b, required 0", bus64.busy); end
    if (bus64.line_len !== 7'd0) begin n_fail++; $display("FAIL drop_exit_len: got %0d, required 0", bus64.line_len); end
    cap0.delete();
    send_byte(0, 8'h6B);
    send_byte(0, CHAR_CR);
    k = 0;
    while (cap0.size() < 1 && k < 300) begin @(negedge clk); k++; end
    send_byte(0, 8'h72);
    n_chk++;
    if (bus64.line_len !== 7'd1) begin n_fail++; $display("FAIL drop_mid_len: got %0d, required 1", bus64.line_len); end
    wait_idle(0, "drop");
    n_chk += 3;
    if (cap0.size() != 3) begin n_fail++; $display("FAIL drop_count: got %0d strobes, required 3", cap0.size()); end
    if ((cap0.size() > 0 ? cap0[0] : -1) != 'h6B) begin n_fail++; $display("FAIL drop_byte0: got %0h, required 6b", (cap0.size() > 0 ? cap0[0] : -1)); end
    if (bus64.dropped !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b, required 1", bus64.dropped); end
  endtask

  task automatic test_hold_and_reset();
    int exp [$] = '{'h78, 'h0D, 'h0A};
    int got;
    hold_high = 1'b1;
    cap0.delete();
    send_byte(0, 8'h68);
    send_byte(0, CHAR_CR);
    repeat (40) @(negedge clk);
    n_chk += 3;
    if (cap0.size() != 1) begin n_fail++; $display("FAIL hold_count: got %0d strobes, required 1", cap0.size()); end
    if ((cap0.size() > 0 ? cap0[0] : -1) != 'h68) begin n_fail++; $display("FAIL hold_byte: got %0h, required 68", (cap0.size() > 0 ? cap0[0] : -1)); end
    if (bus64.busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy: got %b, required 1", bus64.busy); end
    rst_n = 1'b0;
    @(negedge clk);
    n_chk += 6;
    if (bus64.line_len !== 7'd0)    begin n_fail++; $display("FAIL mid_rst_len: got %0d, required 0", bus64.line_len); end
    if (bus64.busy !== 1'b0)        begin n_fail++; $display("FAIL mid_rst_busy: got %b, required 0", bus64.busy); end
    if (bus64.tx_new_data !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stb: got %b, required 0", bus64.tx_new_data); end
    if (bus64.tx_char !== 8'h00)    begin n_fail++; $display("FAIL mid_rst_char: got %h, required 00", bus64.tx_char); end
    if (bus64.overflow !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_ovf: got %b, required 0", bus64.overflow); end
    if (bus64.dropped !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_drop: got %b, required 0", bus64.dropped); end
    rst_n = 1'b1;
    hold_high = 1'b0;
    @(negedge clk);
    cap0.delete();
    send_byte(0, 8'h78);
    send_byte(0, CHAR_CR);
    wait_idle(0, "post_rst");
    n_chk++;
    if (cap0.size() != exp.size()) begin n_fail++; $display("FAIL post_rst_count: got %0d strobes, required %0d", cap0.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < cap0.size()) ? cap0[i] : -1;
      n_chk++;
      if (got != exp[i]) begin n_fail++; $display("FAIL post_rst_byte%0d: got %0h, required %0h", i, got, exp[i]); end
    end
  endtask

  initial begin
    hold_high = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rxd[i] = 8'h00;
      rxv[i] = 1'b0;
      rdy[i] = 1'b1;
      cnt[i] = 0;
      prev_stb[i] = 1'b0;
      prev_bsy[i] = 1'b0;
    end
    do_reset();
    test_reset();
    test_abc();
    test_backspace();
    test_overflow();
    test_empty_line();
    test_dropped();
    test_hold_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
